// File: rtl/palette_pkg.sv
// palette_pkg: default palette contents, error colour, fade FSM states and channel width helper
package palette_pkg;
  localparam logic [11:0] ERR_COLOR = 12'hF0F;
  localparam logic [7:0][11:0] PAL0_DEF = {12'hAC5, 12'h435, 12'h6CB, 12'h7BA, 12'hC54, 12'hFFF, 12'hDD0, 12'hBEB};
  localparam logic [3:0][11:0] PAL1_DEF = {12'hBE9, 12'hFFF, 12'h799, 12'hFE0};
  typedef enum logic [1:0] {FADE_IDLE, FADE_RAMP, FADE_HOLD} fade_state_t;
  function automatic int chan_w(input int rgb_w);
    return rgb_w / 3;
  endfunction
  function automatic logic [11:0] default_color(input int pal, input int idx);
    if (pal == 0 && idx < 8) return PAL0_DEF[idx[2:0]];
    if (pal == 1 && idx < 4) return PAL1_DEF[idx[1:0]];
    return ERR_COLOR;
  endfunction
endpackage

// File: rtl/fade_shade.sv
// fade_shade: one colour channel dimmed by the fade level, clamped at zero
//  ch    in  C_W  channel intensity
//  level in  C_W  fade level to subtract
//  shade out C_W  max(ch - level, 0)
module fade_shade #(
  parameter int C_W = 4
) (
  input  logic [C_W-1:0] ch,
  input  logic [C_W-1:0] level,
  output logic [C_W-1:0] shade
);
  assign shade = ch > level ? ch - level : '0;
endmodule

// File: rtl/palette_lut.sv
// palette_lut: multi-palette writable colour lookup with frame-synchronous swap and fade-to-black
//  clk, rst_n                          pixel clock, async active-low reset
//  pix_valid, pix_idx, pix_blank       pixel index stream (2-cycle latency to rgb_out)
//  frame_start, pal_sel                palette swap request, applied at frame_start
//  fade_go                             restart fade ramp from level 0
//  wr_en, wr_pal, wr_idx, wr_data      palette write port; wr_ready / wr_err handshake
//  rgb_out, rgb_valid                  looked-up, faded colour
//  active_pal, fade_level              current palette and fade level
module palette_lut
  import palette_pkg::*;
#(
  parameter  int IDX_W    = 4,
  parameter  int NUM_PAL  = 2,
  parameter  int RGB_W    = 12,
  parameter  int FADE_DIV = 4,
  localparam int PAL_W    = $clog2(NUM_PAL),
  localparam int C_W      = chan_w(RGB_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [IDX_W-1:0] pix_idx,
  input  logic             pix_blank,
  input  logic             frame_start,
  input  logic [PAL_W-1:0] pal_sel,
  input  logic             fade_go,
  input  logic             wr_en,
  input  logic [PAL_W-1:0] wr_pal,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [RGB_W-1:0] wr_data,
  output logic             wr_ready,
  output logic             wr_err,
  output logic [RGB_W-1:0] rgb_out,
  output logic             rgb_valid,
  output logic [PAL_W-1:0] active_pal,
  output logic [C_W-1:0]   fade_level
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam int CNT_W = $clog2(FADE_DIV + 1);
  localparam logic [C_W-1:0] LVL_MAX = '1;
  logic [RGB_W-1:0] mem [NUM_PAL][DEPTH];
  logic [RGB_W-1:0] rd, faded;
  logic             v1, b1, wr_pal_ok, sel_ok;
  fade_state_t      state, state_nx;
  logic [C_W-1:0]   lvl_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  assign wr_pal_ok = 32'(wr_pal) < NUM_PAL;
  assign sel_ok    = 32'(pal_sel) < NUM_PAL;
  // The displayed palette only accepts writes while the beam is blanked.
  assign wr_ready  = wr_pal != active_pal || pix_blank;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int i = 0; i < DEPTH; i++)
          mem[p][i] <= RGB_W'(default_color(p, i));
    end else if (wr_en && wr_ready && wr_pal_ok) begin
      mem[wr_pal][wr_idx] <= wr_data;
    end
  end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    fade_shade #(.C_W(C_W)) u_shade (
      .ch    (rd[c*C_W +: C_W]),
      .level (fade_level),
      .shade (faded[c*C_W +: C_W])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      b1         <= 1'b0;
      rd         <= '0;
      rgb_out    <= '0;
      rgb_valid  <= 1'b0;
      wr_err     <= 1'b0;
      active_pal <= '0;
    end else begin
      v1         <= pix_valid;
      b1         <= pix_blank;
      rd         <= mem[active_pal][pix_idx];
      rgb_out    <= v1 && !b1 ? faded : '0;
      rgb_valid  <= v1;
      wr_err     <= wr_en && !wr_pal_ok;
      active_pal <= frame_start && sel_ok ? pal_sel : active_pal;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FADE_IDLE;
      fade_level <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      fade_level <= lvl_nx;
      cnt        <= cnt_nx;
    end
  end
  // fade_go has priority over a coincident frame_start: the ramp restarts without stepping.
  always_comb begin
    state_nx = state;
    lvl_nx   = fade_level;
    cnt_nx   = cnt;
    if (fade_go) begin
      state_nx = FADE_RAMP;
      lvl_nx   = '0;
      cnt_nx   = '0;
    end else if (state == FADE_RAMP && frame_start) begin
      if (cnt == CNT_W'(FADE_DIV - 1)) begin
        cnt_nx   = '0;
        lvl_nx   = fade_level + 1'b1;
        state_nx = lvl_nx == LVL_MAX ? FADE_HOLD : FADE_RAMP;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: directed and randomized checks of palette_lut against a frame-counting reference model
module tb_palette_lut;
  localparam int IDX_W = 4, NUM_PAL = 3, RGB_W = 12, FADE_DIV = 4, PAL_W = 2, C_W = 4;
  logic             clk = 1'b0, rst_n = 1'b0;
  logic             pix_valid = 1'b0, pix_blank = 1'b0, frame_start = 1'b0, fade_go = 1'b0, wr_en = 1'b0;
  logic [IDX_W-1:0] pix_idx = '0, wr_idx = '0;
  logic [PAL_W-1:0] pal_sel = '0, wr_pal = '0;
  logic [RGB_W-1:0] wr_data = '0;
  logic             wr_ready, wr_err, rgb_valid;
  logic [RGB_W-1:0] rgb_out;
  logic [PAL_W-1:0] active_pal;
  logic [C_W-1:0]   fade_level;
  int tests = 0, fails = 0;
  logic [11:0] m_mem [NUM_PAL][16];
  int  m_act, m_fcount;
  bit  m_fading;
  logic [11:0] def0 [8] = '{12'hBEB, 12'hDD0, 12'hFFF, 12'hC54, 12'h7BA, 12'h6CB, 12'h435, 12'hAC5};
  logic [11:0] def1 [4] = '{12'hFE0, 12'h799, 12'hFFF, 12'hBE9};
  logic [11:0] exp_c;

  always #5 clk = ~clk;

  palette_lut #(.IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .RGB_W(RGB_W), .FADE_DIV(FADE_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_idx(pix_idx), .pix_blank(pix_blank),
    .frame_start(frame_start), .pal_sel(pal_sel), .fade_go(fade_go), .wr_en(wr_en), .wr_pal(wr_pal),
    .wr_idx(wr_idx), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err), .rgb_out(rgb_out),
    .rgb_valid(rgb_valid), .active_pal(active_pal), .fade_level(fade_level)
  );

  function automatic void model_reset();
    for (int p = 0; p < NUM_PAL; p++)
      for (int i = 0; i < 16; i++)
        m_mem[p][i] = 12'hF0F;
    for (int i = 0; i < 8; i++) m_mem[0][i] = def0[i];
    for (int i = 0; i < 4; i++) m_mem[1][i] = def1[i];
    m_act = 0;
    m_fcount = 0;
    m_fading = 0;
  endfunction

  // fade level = completed FADE_DIV-frame groups since the last fade_go, capped at full black
  function automatic int m_level();
    int l;
    l = m_fcount / FADE_DIV;
    return m_fading ? (l > 15 ? 15 : l) : 0;
  endfunction

  function automatic logic [11:0] shade(input logic [11:0] c, input int lvl);
    int r, ch;
    r = 0;
    for (int k = 0; k < 3; k++) begin
      ch = int'((c >> (4 * k)) & 12'hF);
      ch = ch > lvl ? ch - lvl : 0;
      r += ch << (4 * k);
    end
    return 12'(r);
  endfunction

  function automatic void model_frame(input int sel);
    if (sel < NUM_PAL) m_act = sel;
    if (m_fading) m_fcount++;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int idx, input bit blank);
    pix_valid = 1'b1;
    pix_idx   = 4'(idx);
    pix_blank = blank;
    cyc();
    pix_valid = 1'b0;
    pix_blank = 1'b0;
    cyc();
  endtask

  task automatic frame(input int sel);
    frame_start = 1'b1;
    pal_sel     = 2'(sel);
    cyc();
    frame_start = 1'b0;
    model_frame(sel);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    tests++; if (rgb_out !== 12'h000) begin fails++; $display("FAIL reset_rgb_out got=%h exp=000", rgb_out); end
    tests++; if (rgb_valid !== 1'b0) begin fails++; $display("FAIL reset_rgb_valid got=%b exp=0", rgb_valid); end
    tests++; if (active_pal !== 2'd0) begin fails++; $display("FAIL reset_active_pal got=%0d exp=0", active_pal); end
    tests++; if (fade_level !== 4'd0) begin fails++; $display("FAIL reset_fade_level got=%0d exp=0", fade_level); end
    tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    rst_n = 1'b1;
    model_reset();
    cyc();
  endtask

  task automatic test_lookup();
    int idx;
    pix_valid = 1'b1;
    pix_idx   = 4'd3;
    cyc();
    pix_valid = 1'b0;
    tests++; if (rgb_valid !== 1'b0) begin fails++; $display("FAIL lookup_latency1 rgb_valid got=%b exp=0", rgb_valid); end
    cyc();
    tests++; if (rgb_out !== 12'hC54) begin fails++; $display("FAIL lookup_idx3 rgb_out got=%h exp=C54", rgb_out); end
    tests++; if (rgb_valid !== 1'b1) begin fails++; $display("FAIL lookup_idx3 rgb_valid got=%b exp=1", rgb_valid); end
    cyc();
    tests++; if (rgb_valid !== 1'b0 || rgb_out !== 12'h000) begin fails++; $display("FAIL lookup_novalid got=%b/%h exp=0/000", rgb_valid, rgb_out); end
    for (int n = 0; n < 6; n++) begin
      idx = $urandom_range(0, 15);
      exp_c = shade(m_mem[m_act][idx], m_level());
      pix(idx, 1'b0);
      tests++; if (rgb_out !== exp_c) begin fails++; $display("FAIL lookup_rand idx=%0d got=%h exp=%h", idx, rgb_out, exp_c); end
    end
    pix(2, 1'b1);
    tests++; if (rgb_out !== 12'h000 || rgb_valid !== 1'b1) begin fails++; $display("FAIL lookup_blank got=%b/%h exp=1/000", rgb_valid, rgb_out); end
  endtask

  task automatic test_swap();
    pal_sel = 2'd1;
    pix(1, 1'b0);
    tests++; if (rgb_out !== 12'hDD0) begin fails++; $display("FAIL swap_midframe got=%h exp=DD0", rgb_out); end
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_idx     = 4'd1;
    cyc();
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    model_frame(1);
    tests++; if (active_pal !== 2'd1) begin fails++; $display("FAIL swap_active got=%0d exp=1", active_pal); end
    cyc();
    tests++; if (rgb_out !== 12'hDD0) begin fails++; $display("FAIL swap_inflight got=%h exp=DD0", rgb_out); end
    pix(1, 1'b0);
    tests++; if (rgb_out !== 12'h799) begin fails++; $display("FAIL swap_newpal got=%h exp=799", rgb_out); end
    frame(3);
    tests++; if (active_pal !== 2'd1) begin fails++; $display("FAIL swap_badsel got=%0d exp=1", active_pal); end
    frame(0);
    tests++; if (active_pal !== 2'd0) begin fails++; $display("FAIL swap_back got=%0d exp=0", active_pal); end
  endtask

  task automatic test_write();
    wr_en = 1'b1; wr_pal = 2'd0; wr_idx = 4'd5; wr_data = 12'h123; pix_blank = 1'b0;
    #1;
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL write_active_visible wr_ready got=%b exp=0", wr_ready); end
    cyc();
    wr_en = 1'b0;
    pix(5, 1'b0);
    tests++; if (rgb_out !== 12'h6CB) begin fails++; $display("FAIL write_rejected got=%h exp=6CB", rgb_out); end
    wr_en = 1'b1; pix_blank = 1'b1;
    #1;
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL write_active_blank wr_ready got=%b exp=1", wr_ready); end
    cyc();
    m_mem[0][5] = 12'h123;
    wr_en = 1'b0; pix_blank = 1'b0;
    pix(5, 1'b0);
    tests++; if (rgb_out !== 12'h123) begin fails++; $display("FAIL write_accepted got=%h exp=123", rgb_out); end
    wr_en = 1'b1; wr_pal = 2'd3; wr_idx = 4'd5; wr_data = 12'hABC;
    #1;
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL write_badpal wr_ready got=%b exp=1", wr_ready); end
    cyc();
    wr_en = 1'b0;
    tests++; if (wr_err !== 1'b1) begin fails++; $display("FAIL write_err_pulse got=%b exp=1", wr_err); end
    cyc();
    tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL write_err_clear got=%b exp=0", wr_err); end
    pix(5, 1'b0);
    tests++; if (rgb_out !== 12'h123) begin fails++; $display("FAIL write_badpal_nochange got=%h exp=123", rgb_out); end
    wr_en = 1'b1; wr_pal = 2'd1; wr_idx = 4'd2; wr_data = 12'h9A5;
    frame_start = 1'b1; pal_sel = 2'd1; pix_valid = 1'b1; pix_idx = 4'd2;
    #1;
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL write_preswap_ready got=%b exp=1", wr_ready); end
    exp_c = m_mem[m_act][2];
    cyc();
    m_mem[1][2] = 12'h9A5;
    model_frame(1);
    wr_en = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    cyc();
    tests++; if (rgb_out !== exp_c) begin fails++; $display("FAIL write_sameentry_old got=%h exp=%h", rgb_out, exp_c); end
    pix(2, 1'b0);
    tests++; if (rgb_out !== 12'h9A5) begin fails++; $display("FAIL write_sameentry_new got=%h exp=9A5", rgb_out); end
    wr_en = 1'b1; wr_pal = 2'd1; wr_idx = 4'd3; wr_data = 12'h777; frame_start = 1'b1; pal_sel = 2'd0;
    #1;
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL write_preswap_busy got=%b exp=0", wr_ready); end
    cyc();
    model_frame(0);
    wr_en = 1'b0; frame_start = 1'b0;
  endtask

  task automatic test_fade();
    fade_go = 1'b1;
    cyc();
    fade_go = 1'b0;
    m_fading = 1; m_fcount = 0;
    for (int n = 0; n < 3; n++) frame(0);
    tests++; if (fade_level !== 4'd0) begin fails++; $display("FAIL fade_3frames got=%0d exp=0", fade_level); end
    frame(0);
    tests++; if (fade_level !== 4'd1) begin fails++; $display("FAIL fade_4frames got=%0d exp=1", fade_level); end
    pix(2, 1'b0);
    tests++; if (rgb_out !== 12'hEEE) begin fails++; $display("FAIL fade_lvl1_out got=%h exp=EEE", rgb_out); end
    for (int n = 0; n < 56; n++) frame(0);
    tests++; if (fade_level !== 4'd15) begin fails++; $display("FAIL fade_60frames got=%0d exp=15", fade_level); end
    for (int n = 0; n < 5; n++) frame(0);
    tests++; if (fade_level !== 4'd15) begin fails++; $display("FAIL fade_hold got=%0d exp=15", fade_level); end
    pix(2, 1'b0);
    tests++; if (rgb_out !== 12'h000) begin fails++; $display("FAIL fade_black got=%h exp=000", rgb_out); end
    fade_go = 1'b1; frame_start = 1'b1; pal_sel = 2'd0;
    cyc();
    fade_go = 1'b0; frame_start = 1'b0;
    m_fcount = 0;
    tests++; if (fade_level !== 4'd0) begin fails++; $display("FAIL fade_restart got=%0d exp=0", fade_level); end
    for (int n = 0; n < 3; n++) frame(0);
    tests++; if (fade_level !== 4'd0) begin fails++; $display("FAIL fade_restart_noinc got=%0d exp=0", fade_level); end
    for (int n = 0; n < 17; n++) frame(0);
    tests++; if (fade_level !== 4'(m_level())) begin fails++; $display("FAIL fade_lvl5 got=%0d exp=%0d", fade_level, m_level()); end
    pix(3, 1'b0);
    tests++; if (rgb_out !== 12'h700) begin fails++; $display("FAIL fade_saturate got=%h exp=700", rgb_out); end
  endtask

  task automatic test_reset_mid();
    pix_valid = 1'b1; pix_idx = 4'd2;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (rgb_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got=%b exp=0", rgb_valid); end
    tests++; if (fade_level !== 4'd0) begin fails++; $display("FAIL rstmid_level got=%0d exp=0", fade_level); end
    cyc();
    tests++; if (rgb_valid !== 1'b0) begin fails++; $display("FAIL rstmid_held got=%b exp=0", rgb_valid); end
    rst_n = 1'b1;
    pix_valid = 1'b0;
    model_reset();
    cyc();
    pix(5, 1'b0);
    tests++; if (rgb_out !== 12'h6CB) begin fails++; $display("FAIL rstmid_defaults got=%h exp=6CB", rgb_out); end
    for (int n = 0; n < 4; n++) frame(0);
    tests++; if (fade_level !== 4'd0) begin fails++; $display("FAIL rstmid_idle got=%0d exp=0", fade_level); end
  endtask

  task automatic test_random();
    bit p_v, p_b, e_v, e_err, e_rdy;
    logic [11:0] p_c, e_o;
    int bad = 0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    model_reset();
    p_v = 0; p_b = 0; p_c = '0;
    for (int n = 0; n < 800; n++) begin
      pix_valid   = $urandom_range(0, 3) != 0;
      pix_idx     = 4'($urandom);
      pix_blank   = $urandom_range(0, 2) == 0;
      frame_start = $urandom_range(0, 3) == 0;
      pal_sel     = 2'($urandom);
      fade_go     = $urandom_range(0, 99) == 0;
      wr_en       = $urandom_range(0, 1) == 1;
      wr_pal      = 2'($urandom);
      wr_idx      = 4'($urandom);
      wr_data     = 12'($urandom);
      #1;
      e_rdy = int'(wr_pal) != m_act || pix_blank;
      tests++; if (wr_ready !== e_rdy) begin fails++; bad++; if (bad < 10) $display("FAIL rand_wr_ready cyc=%0d got=%b exp=%b", n, wr_ready, e_rdy); end
      e_v   = p_v;
      e_o   = p_v && !p_b ? shade(p_c, m_level()) : 12'h000;
      e_err = wr_en && wr_pal >= NUM_PAL;
      p_v = pix_valid; p_b = pix_blank; p_c = m_mem[m_act][pix_idx];
      if (wr_en && e_rdy && wr_pal < NUM_PAL) m_mem[wr_pal][wr_idx] = wr_data;
      if (fade_go) begin
        m_fading = 1; m_fcount = 0;
        if (frame_start && pal_sel < NUM_PAL) m_act = int'(pal_sel);
      end else if (frame_start) model_frame(int'(pal_sel));
      cyc();
      tests++; if (rgb_out !== e_o || rgb_valid !== e_v) begin fails++; bad++; if (bad < 10) $display("FAIL rand_rgb cyc=%0d got=%b/%h exp=%b/%h", n, rgb_valid, rgb_out, e_v, e_o); end
      tests++; if (wr_err !== e_err) begin fails++; bad++; if (bad < 10) $display("FAIL rand_wr_err cyc=%0d got=%b exp=%b", n, wr_err, e_err); end
      tests++; if (active_pal !== 2'(m_act) || fade_level !== 4'(m_level())) begin fails++; bad++; if (bad < 10) $display("FAIL rand_state cyc=%0d got=%0d/%0d exp=%0d/%0d", n, active_pal, fade_level, m_act, m_level()); end
    end
    pix_valid = 1'b0; frame_start = 1'b0; fade_go = 1'b0; wr_en = 1'b0; pix_blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_swap();
    test_write();
    test_fade();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
